// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requests onto one req/ack memory port, one transaction in flight.
// Optional ARB_TIMEOUT_EN adds a busy-cycle watchdog with a sticky timeout_err output.
module mem_port_arbiter #(
  parameter int DATAW            = 32,
  parameter int FETCH_STARVE_MAX = 4,
  parameter int TIMEOUT_CYCLES   = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             f_req,
  input  logic [DATAW-1:0] f_addr,
  output logic             f_gnt,
  output logic             f_valid,
  output logic [DATAW-1:0] f_rdata,
  input  logic             d_req,
  input  logic             d_rw,
  input  logic [DATAW-1:0] d_addr,
  input  logic [DATAW-1:0] d_wdata,
  input  logic [1:0]       d_size,
  input  logic             d_unsigned,
  output logic             d_gnt,
  output logic             d_valid,
  output logic [DATAW-1:0] d_rdata,
  output logic             m_req,
  output logic             m_rw,
  output logic [DATAW-1:0] m_addr,
  output logic [DATAW-1:0] m_wdata,
  output logic [1:0]       m_size,
  output logic             m_unsigned,
  input  logic             m_ack,
  input  logic [DATAW-1:0] m_rdata
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  localparam int SW = $clog2(FETCH_STARVE_MAX + 1);
  localparam logic [DATAW-1:0] BAD_DATA = DATAW'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

  state_t           r_state;
  logic [SW-1:0]    r_streak;
  logic             r_m_req, r_m_rw, r_m_unsigned;
  logic [DATAW-1:0] r_m_addr, r_m_wdata;
  logic [1:0]       r_m_size;
  logic             r_f_valid, r_d_valid;
  logic [DATAW-1:0] r_f_rdata, r_d_rdata;

  logic             w_idle, w_starved, w_gnt_d, w_gnt_f;
  logic             w_timeout, w_done;
  logic [DATAW-1:0] w_ret_data;

  assign w_idle    = (r_state == IDLE);
  assign w_starved = f_req && (r_streak == SW'(FETCH_STARVE_MAX));
  assign w_gnt_d   = w_idle && d_req && !w_starved;
  assign w_gnt_f   = w_idle && f_req && !w_gnt_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_busy_cnt;
  logic          r_timeout_err;

  assign w_timeout   = !w_idle && !m_ack && (r_busy_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_gnt_d || w_gnt_f)
        r_busy_cnt <= '0;
      else if (!w_idle)
        r_busy_cnt <= r_busy_cnt + CW'(1);
      if (w_timeout)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // An ack on the watchdog's final cycle wins over the timeout.
  assign w_done     = m_ack || w_timeout;
  assign w_ret_data = m_ack ? m_rdata : BAD_DATA;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_m_req      <= 1'b0;
      r_m_rw       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_m_size     <= '0;
      r_m_unsigned <= 1'b0;
      r_f_valid    <= 1'b0;
      r_d_valid    <= 1'b0;
      r_f_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_f_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt_d) begin
            r_state      <= BUSY_D;
            r_m_req      <= 1'b1;
            r_m_rw       <= d_rw;
            r_m_addr     <= d_addr;
            r_m_wdata    <= d_wdata;
            r_m_size     <= d_size;
            r_m_unsigned <= d_unsigned;
            if (!f_req)
              r_streak <= '0;
            else if (r_streak != SW'(FETCH_STARVE_MAX))
              r_streak <= r_streak + SW'(1);
          end else if (w_gnt_f) begin
            r_state      <= BUSY_F;
            r_m_req      <= 1'b1;
            r_m_rw       <= 1'b0;
            r_m_addr     <= f_addr;
            r_m_wdata    <= '0;
            r_m_size     <= 2'd2;
            r_m_unsigned <= 1'b0;
            r_streak     <= '0;
          end
        end
        BUSY_F: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_f_valid <= 1'b1;
            r_f_rdata <= w_ret_data;
          end
        end
        BUSY_D: begin
          if (w_done) begin
            r_state   <= IDLE;
            r_m_req   <= 1'b0;
            r_d_valid <= 1'b1;
            if (!r_m_rw || w_timeout)
              r_d_rdata <= w_ret_data;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_gnt      = w_gnt_f;
  assign d_gnt      = w_gnt_d;
  assign f_valid    = r_f_valid;
  assign f_rdata    = r_f_rdata;
  assign d_valid    = r_d_valid;
  assign d_rdata    = r_d_rdata;
  assign m_req      = r_m_req;
  assign m_rw       = r_m_rw;
  assign m_addr     = r_m_addr;
  assign m_wdata    = r_m_wdata;
  assign m_size     = r_m_size;
  assign m_unsigned = r_m_unsigned;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences, random vs. transaction model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        f_req, d_req, d_rw, d_unsigned, m_ack;
  logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic        f_gnt, f_valid, d_gnt, d_valid, m_req, m_rw, m_unsigned;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.DATAW(32), .FETCH_STARVE_MAX(SMAX), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
    .d_unsigned(d_unsigned), .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_size(m_size),
    .m_unsigned(m_unsigned), .m_ack(m_ack), .m_rdata(m_rdata)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        f_req, d_req, d_rw, m_ack;
    logic [31:0] f_addr, d_addr, m_rdata;
    logic        e_fg, e_dg, e_mreq, e_mrw, e_fv, e_dv;
    logic [31:0] e_maddr, e_frd, e_drd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs;
    f_req = 0; f_addr = '0; d_req = 0; d_rw = 0; d_addr = '0; d_wdata = '0;
    d_size = 2'd2; d_unsigned = 0; m_ack = 0; m_rdata = '0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    zero_inputs();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_fgnt", f_gnt, 0);     chk("rst_dgnt", d_gnt, 0);
    chk("rst_mreq", m_req, 0);     chk("rst_maddr", m_addr, 0);
    chk("rst_mwdata", m_wdata, 0); chk("rst_msize", m_size, 0);
    chk("rst_fv", f_valid, 0);     chk("rst_dv", d_valid, 0);
    chk("rst_frd", f_rdata, 0);    chk("rst_drd", d_rdata, 0);
    reset_n = 1'b1;
  endtask

  function automatic vec_t mkv(logic fr, logic [31:0] fa, logic dr, logic [31:0] da, logic ack,
                               logic [31:0] rd, logic fg, logic dg, logic mr, logic [31:0] ma,
                               logic fv, logic [31:0] frd, logic dv, logic [31:0] drd);
    vec_t v;
    v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_addr = da; v.d_rw = 1'b0;
    v.m_ack = ack; v.m_rdata = rd; v.e_fg = fg; v.e_dg = dg; v.e_mreq = mr;
    v.e_mrw = 1'b0; v.e_maddr = ma; v.e_fv = fv; v.e_frd = frd; v.e_dv = dv; v.e_drd = drd;
    return v;
  endfunction

  // Reference-model state for the random phase
  bit          mb, mf, t_rw, t_uns, ev_f, ev_d, egd, egf, f_hold, d_hold;
  logic [31:0] t_addr, t_wdata, e_frd, e_drd;
  logic [1:0]  t_size;
  int          streak, ngd;
  bit          got_f;

  initial begin
    vecs[0] = mkv(1, 32'h01000000, 0, 0,            0, 0,     1, 0, 0, 0,            0, 0,     0, 0);
    vecs[1] = mkv(0, 0,            0, 0,            1, 32'h13, 0, 0, 1, 32'h01000000, 0, 0,     0, 0);
    vecs[2] = mkv(0, 0,            0, 0,            0, 0,     0, 0, 0, 0,            1, 32'h13, 0, 0);
    vecs[3] = mkv(1, 32'h01000004, 1, 32'h01000100, 0, 0,     0, 1, 0, 0,            0, 32'h13, 0, 0);
    vecs[4] = mkv(1, 32'h01000004, 0, 0,            1, 32'h55, 0, 0, 1, 32'h01000100, 0, 32'h13, 0, 0);
    vecs[5] = mkv(1, 32'h01000004, 0, 0,            0, 0,     1, 0, 0, 0,            0, 32'h13, 1, 32'h55);
    vecs[6] = mkv(0, 0,            0, 0,            1, 32'h77, 0, 0, 1, 32'h01000004, 0, 32'h13, 0, 32'h55);
    vecs[7] = mkv(0, 0,            0, 0,            1, 32'h99, 0, 0, 0, 0,            1, 32'h77, 0, 32'h55);
    vecs[8] = mkv(0, 0,            0, 0,            0, 0,     0, 0, 0, 0,            0, 32'h77, 0, 32'h55);

    reset_n = 1'b0;
    zero_inputs();
    #1;
    chk("rst_async_mreq", m_req, 0);
    do_reset();

    // Directed vector table
    for (int unsigned i = 0; i < 9; i++) begin
      f_req = vecs[i].f_req; f_addr = vecs[i].f_addr; d_req = vecs[i].d_req;
      d_addr = vecs[i].d_addr; d_rw = vecs[i].d_rw; m_ack = vecs[i].m_ack; m_rdata = vecs[i].m_rdata;
      @(negedge clock);
      chk($sformatf("v%0d_fgnt", i), f_gnt, vecs[i].e_fg);
      chk($sformatf("v%0d_dgnt", i), d_gnt, vecs[i].e_dg);
      chk($sformatf("v%0d_mreq", i), m_req, vecs[i].e_mreq);
      chk($sformatf("v%0d_fv", i), f_valid, vecs[i].e_fv);
      chk($sformatf("v%0d_dv", i), d_valid, vecs[i].e_dv);
      chk($sformatf("v%0d_frd", i), f_rdata, vecs[i].e_frd);
      chk($sformatf("v%0d_drd", i), d_rdata, vecs[i].e_drd);
      if (vecs[i].e_mreq) begin
        chk($sformatf("v%0d_maddr", i), m_addr, vecs[i].e_maddr);
        chk($sformatf("v%0d_mrw", i), m_rw, vecs[i].e_mrw);
      end
      tick();
    end

    // Starvation: data back-to-back with fetch pending
    do_reset();
    f_req = 1; f_addr = 32'h01000040; d_req = 1; d_addr = 32'h01000200; m_ack = 1; m_rdata = 32'h1;
    ngd = 0; got_f = 0;
    for (int unsigned c = 0; c < 40 && !got_f; c++) begin
      @(negedge clock);
      if (d_gnt) ngd++;
      if (f_gnt) got_f = 1;
      tick();
    end
    chk("starve_dgrants", ngd, SMAX);
    chk("starve_fgnt", got_f, 1);
    @(negedge clock);
    chk("starve_fbusy", m_req, 1);
    tick();
    @(negedge clock);
    chk("starve_cleared_dgnt", d_gnt, 1);
    tick();
    zero_inputs();
    repeat (3) tick();

    // Store (latency 3) then load
    do_reset();
    d_req = 1; d_rw = 1; d_addr = 32'h02000010; d_wdata = 32'hCAFEBABE; d_size = 0;
    @(negedge clock);
    chk("st_dgnt", d_gnt, 1);
    tick();
    d_req = 0; d_wdata = 32'h0BAD0BAD; d_size = 2;
    for (int unsigned k = 0; k < 3; k++) begin
      if (k == 2) begin m_ack = 1; m_rdata = 32'h12345678; end
      @(negedge clock);
      chk($sformatf("st_mreq%0d", k), m_req, 1);
      chk($sformatf("st_mwdata%0d", k), m_wdata, 32'hCAFEBABE);
      chk($sformatf("st_msize%0d", k), m_size, 0);
      chk($sformatf("st_mrw%0d", k), m_rw, 1);
      tick();
    end
    m_ack = 0;
    @(negedge clock);
    chk("st_dv", d_valid, 1);
    chk("st_drd_unchanged", d_rdata, 0);
    chk("st_mreq_drop", m_req, 0);
    tick();
    d_req = 1; d_rw = 0; d_addr = 32'h02000020; d_size = 2;
    @(negedge clock);
    chk("ld_dgnt", d_gnt, 1);
    tick();
    d_req = 0; m_ack = 1; m_rdata = 32'hA5A50F0F;
    @(negedge clock);
    chk("ld_mreq", m_req, 1);
    chk("ld_mrw", m_rw, 0);
    tick();
    m_ack = 0;
    @(negedge clock);
    chk("ld_dv", d_valid, 1);
    chk("ld_drd", d_rdata, 32'hA5A50F0F);
    tick();

    // Reset in the middle of a data transaction
    do_reset();
    d_req = 1; d_rw = 0; d_addr = 32'h03000000;
    @(negedge clock);
    chk("rm_dgnt", d_gnt, 1);
    tick();
    d_req = 0;
    @(negedge clock);
    chk("rm_busy", m_req, 1);
    #1 reset_n = 0;
    #1 chk("rm_mreq_async", m_req, 0);
    @(posedge clock);
    #1;
    reset_n = 1; m_ack = 1; m_rdata = 32'hFEEDFACE;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("rm_dv%0d", k), d_valid, 0);
      chk($sformatf("rm_fv%0d", k), f_valid, 0);
      chk($sformatf("rm_mreq%0d", k), m_req, 0);
      chk($sformatf("rm_drd%0d", k), d_rdata, 0);
      tick();
    end

    // Randomized traffic against a transaction-level model
    do_reset();
    mb = 0; mf = 0; t_rw = 0; t_uns = 0; t_addr = 0; t_wdata = 0; t_size = 0;
    ev_f = 0; ev_d = 0; e_frd = 0; e_drd = 0; streak = 0; f_hold = 0; d_hold = 0;
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      if (f_hold) begin
        if ($urandom % 16 == 0) f_req = 0;
      end else begin
        f_req = ($urandom % 3) != 0; f_addr = $urandom;
      end
      if (d_hold) begin
        if ($urandom % 16 == 0) d_req = 0;
      end else begin
        d_req = ($urandom % 3) != 0; d_rw = $urandom % 2; d_addr = $urandom;
        d_wdata = $urandom; d_size = 2'($urandom % 3); d_unsigned = $urandom % 2;
      end
      m_ack = mb ? (($urandom % 3) == 0) : (($urandom % 8) == 0);
      m_rdata = $urandom;

      egd = !mb && d_req && !(f_req && streak == SMAX);
      egf = !mb && f_req && !egd;
      @(negedge clock);
      chk("rnd_fgnt", f_gnt, egf);
      chk("rnd_dgnt", d_gnt, egd);
      chk("rnd_mreq", m_req, mb);
      chk("rnd_fv", f_valid, ev_f);
      chk("rnd_dv", d_valid, ev_d);
      chk("rnd_frd", f_rdata, e_frd);
      chk("rnd_drd", d_rdata, e_drd);
      if (mb) begin
        chk("rnd_maddr", m_addr, t_addr);
        chk("rnd_mrw", m_rw, t_rw);
        chk("rnd_msize", m_size, t_size);
        chk("rnd_muns", m_unsigned, t_uns);
        if (t_rw) chk("rnd_mwdata", m_wdata, t_wdata);
      end

      ev_f = 0; ev_d = 0;
      if (mb) begin
        if (m_ack) begin
          mb = 0;
          if (mf) begin ev_f = 1; e_frd = m_rdata; end
          else begin ev_d = 1; if (!t_rw) e_drd = m_rdata; end
        end
      end else if (egd) begin
        mb = 1; mf = 0; t_addr = d_addr; t_rw = d_rw; t_wdata = d_wdata;
        t_size = d_size; t_uns = d_unsigned;
        streak = f_req ? ((streak + 1 > SMAX) ? SMAX : streak + 1) : 0;
      end else if (egf) begin
        mb = 1; mf = 1; t_addr = f_addr; t_rw = 0; t_size = 2; t_uns = 0; streak = 0;
      end
      f_hold = f_req && !egf;
      d_hold = d_req && !egd;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
